pc_gen_unit: RTL
================

Name: pc_gen_unit

Overview:
- Parametrised program-counter generator for the pipelined RV64 fetch stage. It supersedes the bare PC register.
- Adds a fetch valid/ready handshake, stall hold, branch redirect, trap redirect, misaligned-target detection, and a small return-address stack (RAS) for predicted returns.
- Sits between the control/hazard unit and the instruction-memory fetch port.

Parameters:
- XLEN, 64, PC and address width in bits.
- RESET_VECTOR, 64'h0, PC value loaded while reset is high.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, RAS entry count (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall; hold PC.
- fetch_ready  in  1  fetch port accepts pc_out this cycle.
- redirect_valid  in  1  branch/jump resolved taken.
- redirect_target  in  XLEN  redirect destination.
- trap_valid  in  1  exception/interrupt entry.
- trap_vector  in  XLEN  trap handler address.
- call_push  in  1  current fetch is a call; push pc_out+INC.
- ret_pop  in  1  current fetch is a predicted return; next PC = RAS top.
- pc_out  out  XLEN  current fetch PC.
- pc_valid  out  1  pc_out is valid for fetch.
- misalign_err  out  1  one-cycle pulse: last loaded target had bits [1:0] ≠ 0.
- ras_empty  out  1  RAS count == 0.

Behaviour:
- Reset (synchronous, active-high; clock clk): pc_out=RESET_VECTOR, pc_valid=0, misalign_err=0, RAS count=0, top pointer=0, ras_empty=1. Reset asserted mid-operation overrides all other inputs on that edge.
- pc_valid becomes 1 on the first edge with reset low and stays 1 until the next reset.
- fire = pc_valid & fetch_ready & ~stall.
- Next-PC priority, evaluated per edge (highest first):
  1. reset
  2. trap_valid → trap_vector
  3. redirect_valid → redirect_target
  4. fire & ret_pop & ~ras_empty → RAS top
  5. fire → pc_out + INC
  6. hold
- Trap and redirect apply regardless of stall, fetch_ready and pc_valid. Latency is 1 cycle: the target appears on pc_out the cycle after assertion.
- Misalignment: a trap or redirect target with bits [1:0] ≠ 0 is loaded with bits [1:0] forced to 0, and misalign_err=1 for exactly the following cycle. Otherwise misalign_err=0.
- Arithmetic: pc_out + INC is modulo 2^XLEN and wraps silently (all-ones−3 → 0).
- RAS operations occur only on fire cycles with no trap or redirect. Otherwise call_push and ret_pop are ignored.
- Push: write pc_out+INC at top+1 and advance top. If count < RAS_DEPTH, count++. If full, the pointer wraps and the oldest entry is overwritten; count stays at RAS_DEPTH.
- Pop with ras_empty=1: ignored; PC takes the sequential path.
- Pop: top−1 and count−1.
- Simultaneous push and pop: next PC = old top. The new return address replaces the top slot; count and pointer are unchanged.
- trap_valid clears the RAS (count=0). redirect_valid leaves the RAS unchanged.
- Stall with no trap/redirect: pc_out, pc_valid and RAS are all held.

Decomposition:
- Package pc_pkg holds:
  - INSN_ALIGN_MASK constant.
  - next_pc_sel_t enum {SEL_RESET, SEL_TRAP, SEL_REDIRECT, SEL_RAS, SEL_SEQ, SEL_HOLD}.
  - Default RESET_VECTOR.
- One sub-module, ras_stack, parametrised on XLEN and RAS_DEPTH:
  - inputs: push, pop, push_data, clear
  - outputs: top_data, empty
  - implements the circular pointer and saturating count.
- pc_gen_unit holds the PC register, valid flag, priority mux and misalign logic.

Test Plan:
- Reset held 3 cycles then released, fetch_ready=1 → pc_out=0 with pc_valid=0 during reset; after release pc_valid=1, then pc_out 0, 4, 8, 12 on consecutive cycles.
- At pc_out=0x10, stall=1 for 2 cycles, then fetch_ready=0 for 1 cycle → pc_out held at 0x10 for 3 cycles, then 0x14.
- stall=1 with redirect_valid=1, target 0x200 → next cycle pc_out=0x200. The same edge with trap_valid=1, vector 0x800 → pc_out=0x800 and ras_empty=1.
- Redirect to 0x103 → pc_out=0x100 and misalign_err=1 for exactly one cycle.
- Sequence:
  - call_push at pc 0x00, 0x40, 0x80, 0xC0, 0x100 (depth 4) → RAS holds 0x44, 0x84, 0xC4, 0x104, with 0x04 overwritten.
  - Four ret_pop fires → pc_out goes 0x104, 0xC4, 0x84, 0x44.
  - A fifth ret_pop → sequential pc_out+4.
- pc_out=64'hFFFF_FFFF_FFFF_FFFC with fire → next pc_out=0. Simultaneous call_push and ret_pop with top=0x84 at pc 0x300 → pc_out=0x84, new top=0x304, count unchanged.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and next-PC select encoding for the fetch PC generator
package pc_pkg;
    localparam logic [1:0] INSN_ALIGN_MASK = 2'b11;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;
    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_TRAP,
        SEL_REDIRECT,
        SEL_RAS,
        SEL_SEQ,
        SEL_HOLD
    } next_pc_sel_t;
endpackage

// File: rtl/pc_gen_unit_ras_stack.sv
// ras_stack: circular return-address stack with saturating count; full pushes overwrite the oldest entry
module ras_stack #(
    parameter int XLEN = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0] top_q, top_d, wr_idx;
    logic [PW:0] count_q, count_d;
    logic pop_ok, full;
    assign empty = count_q == '0;
    assign top_data = mem_q[top_q];
    always_comb begin
        full = count_q == (PW+1)'(RAS_DEPTH);
        pop_ok = pop & ~empty;
        // push+pop replaces the top slot in place instead of moving the pointer
        wr_idx = pop_ok ? top_q : top_q + 1'b1;
        mem_d = mem_q;
        if (!clear && push)
            mem_d[wr_idx] = push_data;
        top_d = clear ? '0 : (push && !pop_ok) ? top_q + 1'b1 : (pop_ok && !push) ? top_q - 1'b1 : top_q;
        count_d = clear ? '0 : (push && !pop_ok) ? count_q + (PW+1)'(!full) : (pop_ok && !push) ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge clk) begin
        top_q <= top_d;
        count_q <= count_d;
        mem_q <= mem_d;
    end
endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch PC register with handshake, stall hold, trap/branch redirect, misalign flag and RAS
import pc_pkg::*;
module pc_gen_unit #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int INC = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            call_push,
    input  logic            ret_pop,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            misalign_err,
    output logic            ras_empty
);
    logic [XLEN-1:0] pc_q, pc_d, seq_pc, tgt, ras_top;
    logic pc_valid_q, pc_valid_d, misalign_q, misalign_d;
    logic fire, jump, ras_push, ras_pop, ras_clear;
    next_pc_sel_t sel;
    always_comb begin
        fire = pc_valid_q & fetch_ready & ~stall;
        sel = reset ? SEL_RESET : trap_valid ? SEL_TRAP : redirect_valid ? SEL_REDIRECT :
              (fire & ret_pop & ~ras_empty) ? SEL_RAS : fire ? SEL_SEQ : SEL_HOLD;
        seq_pc = pc_q + XLEN'(INC);
        tgt = trap_valid ? trap_vector : redirect_target;
        jump = sel == SEL_TRAP || sel == SEL_REDIRECT;
        pc_d = sel == SEL_RESET ? RESET_VECTOR : jump ? tgt & ~XLEN'(INSN_ALIGN_MASK) :
               sel == SEL_RAS ? ras_top : sel == SEL_SEQ ? seq_pc : pc_q;
        pc_valid_d = ~reset;
        misalign_d = jump && |(tgt[1:0] & INSN_ALIGN_MASK);
        ras_push = (sel == SEL_RAS || sel == SEL_SEQ) && call_push;
        ras_pop = sel == SEL_RAS;
        ras_clear = reset | trap_valid;
    end
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
        pc_valid_q <= pc_valid_d;
        misalign_q <= misalign_d;
    end
    ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk),
        .clear(ras_clear),
        .push(ras_push),
        .pop(ras_pop),
        .push_data(seq_pc),
        .top_data(ras_top),
        .empty(ras_empty)
    );
    assign pc_out = pc_q;
    assign pc_valid = pc_valid_q;
    assign misalign_err = misalign_q;
endmodule
